// File: rtl/stream_demux2.sv
// 1-to-2 stream demultiplexer: each input beat is routed by in_sel_i into a per-port FIFO.
// Optional per-port saturating pop counters are enabled with the STREAM_DEMUX2_STATS_EN macro.
module stream_demux2 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       in_sel_i,
  output logic                       a_valid_o,
  input  logic                       a_ready_i,
  output logic [DATA_W-1:0]          a_data_o,
  output logic                       b_valid_o,
  input  logic                       b_ready_i,
  output logic [DATA_W-1:0]          b_data_o,
  output logic [$clog2(DEPTH+1)-1:0] a_count_o,
  output logic [$clog2(DEPTH+1)-1:0] b_count_o
`ifdef STREAM_DEMUX2_STATS_EN
  ,
  output logic [15:0]                a_xfer_cnt_o,
  output logic [15:0]                b_xfer_cnt_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Valid/ready: a beat moves on a rising edge only when valid and ready are both high;
  // valid never depends on ready, and a held beat must stay stable until it is taken.

  // Index 0 is port A, index 1 is port B.
  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [DATA_W-1:0] mem_d [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;

  // A full port refuses the beat even if its consumer pops this cycle (no bypass).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      full[p]  = (cnt_q[p] == CNT_W'(DEPTH));
      valid[p] = (cnt_q[p] != '0);
    end
    in_ready_o = !reset && !full[in_sel_i];
    push[0]    = in_valid_i && in_ready_o && !in_sel_i;
    push[1]    = in_valid_i && in_ready_o && in_sel_i;
    pop[0]     = valid[0] && a_ready_i;
    pop[1]     = valid[1] && b_ready_i;
  end

  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < 2; p++) begin
      wr_ptr_d[p] = wr_ptr_q[p];
      rd_ptr_d[p] = rd_ptr_q[p];
      cnt_d[p]    = cnt_q[p];
      if (push[p]) begin
        mem_d[p][wr_ptr_q[p]] = in_data_i;
        wr_ptr_d[p]           = wr_ptr_q[p] + PTR_W'(1);
      end
      if (pop[p]) begin
        rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(1);
      end
      if (push[p] && !pop[p]) begin
        cnt_d[p] = cnt_q[p] + CNT_W'(1);
      end else if (!push[p] && pop[p]) begin
        cnt_d[p] = cnt_q[p] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[p][e] <= '0;
        end
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
    end else begin
      mem_q <= mem_d;
      for (int p = 0; p < 2; p++) begin
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        cnt_q[p]    <= cnt_d[p];
      end
    end
  end

  // Head data comes straight from storage; cleared storage gives zero data after reset.
  assign a_valid_o = valid[0];
  assign b_valid_o = valid[1];
  assign a_data_o  = mem_q[0][rd_ptr_q[0]];
  assign b_data_o  = mem_q[1][rd_ptr_q[1]];
  assign a_count_o = cnt_q[0];
  assign b_count_o = cnt_q[1];

`ifdef STREAM_DEMUX2_STATS_EN
  logic [15:0] xfer_q [2];
  logic [15:0] xfer_d [2];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      xfer_d[p] = xfer_q[p];
      if (pop[p] && (xfer_q[p] != 16'hFFFF)) begin
        xfer_d[p] = xfer_q[p] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_q[0] <= '0;
      xfer_q[1] <= '0;
    end else begin
      xfer_q[0] <= xfer_d[0];
      xfer_q[1] <= xfer_d[1];
    end
  end

  assign a_xfer_cnt_o = xfer_q[0];
  assign b_xfer_cnt_o = xfer_q[1];
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Self-checking bench for stream_demux2: queue-based reference model, randomized traffic.
// Build with STREAM_DEMUX2_STATS_EN defined to also exercise the saturating pop counters.
module tb_stream_demux2;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              in_sel_i;
  logic              a_valid_o;
  logic              a_ready_i;
  logic [DATA_W-1:0] a_data_o;
  logic              b_valid_o;
  logic              b_ready_i;
  logic [DATA_W-1:0] b_data_o;
  logic [CNT_W-1:0]  a_count_o;
  logic [CNT_W-1:0]  b_count_o;
`ifdef STREAM_DEMUX2_STATS_EN
  logic [15:0]       a_xfer_cnt_o;
  logic [15:0]       b_xfer_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  // Expected per-port contents, head at index 0.
  logic [DATA_W-1:0] exp_a_q[$];
  logic [DATA_W-1:0] exp_b_q[$];
  bit                last_acc;
  int                n_pop_a;
  int                n_pop_b;

  stream_demux2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_sel_i     (in_sel_i),
    .a_valid_o    (a_valid_o),
    .a_ready_i    (a_ready_i),
    .a_data_o     (a_data_o),
    .b_valid_o    (b_valid_o),
    .b_ready_i    (b_ready_i),
    .b_data_o     (b_data_o),
    .a_count_o    (a_count_o),
    .b_count_o    (b_count_o)
`ifdef STREAM_DEMUX2_STATS_EN
    ,
    .a_xfer_cnt_o (a_xfer_cnt_o),
    .b_xfer_cnt_o (b_xfer_cnt_o)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock: decide from the current inputs what the ideal block does
  // at this edge, update the model after the edge, and return 1 ns past it.
  task automatic tick();
    bit acc, pa, pb, s;
    logic [DATA_W-1:0] d;
    acc = in_valid_i && !reset &&
          ((in_sel_i ? exp_b_q.size() : exp_a_q.size()) < DEPTH);
    pa  = a_ready_i && (exp_a_q.size() > 0);
    pb  = b_ready_i && (exp_b_q.size() > 0);
    s   = in_sel_i;
    d   = in_data_i;
    @(posedge clk);
    if (pa) begin void'(exp_a_q.pop_front()); n_pop_a++; end
    if (pb) begin void'(exp_b_q.pop_front()); n_pop_b++; end
    if (acc) begin
      if (s) exp_b_q.push_back(d);
      else   exp_a_q.push_back(d);
    end
    last_acc = acc;
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_sel_i   = 1'b0;
    a_ready_i  = 1'b0;
    b_ready_i  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", in_ready_o); end
    checks++; if (a_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b%0b exp=00", a_valid_o, b_valid_o); end
    checks++; if (a_count_o !== '0 || b_count_o !== '0) begin failures++; $display("FAIL rst_count got=%0d/%0d exp=0/0", a_count_o, b_count_o); end
    reset = 1'b0;
    exp_a_q.delete(); exp_b_q.delete(); n_pop_a = 0; n_pop_b = 0;
    // Load two beats into A, then reset in the middle of a cycle.
    in_valid_i = 1'b1; in_sel_i = 1'b0; in_data_i = 8'hA1; tick();
    in_data_i = 8'hA2; tick();
    checks++; if (a_count_o !== CNT_W'(2)) begin failures++; $display("FAIL pre_rst_count got=%0d exp=2", a_count_o); end
    checks++; if (a_data_o !== 8'hA1) begin failures++; $display("FAIL pre_rst_data got=%h exp=a1", a_data_o); end
    #2 reset = 1'b1;
    #1;
    checks++; if (a_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", a_valid_o); end
    checks++; if (a_count_o !== '0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", a_count_o); end
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%0b exp=0", in_ready_o); end
    #2 reset = 1'b0;
    exp_a_q.delete(); exp_b_q.delete(); n_pop_a = 0; n_pop_b = 0;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%0b exp=1", in_ready_o); end
    checks++; if (a_data_o !== 8'h00) begin failures++; $display("FAIL post_rst_data got=%h exp=00", a_data_o); end
    in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    idle_inputs();
    a_ready_i = 1'b1; in_valid_i = 1'b1; in_sel_i = 1'b0; in_data_i = 8'h5A;
    #1;
    checks++; if (in_ready_o !== 1'b1 || a_valid_o !== 1'b0) begin failures++; $display("FAIL single_pre got=rdy%0b/v%0b exp=rdy1/v0", in_ready_o, a_valid_o); end
    tick();
    in_valid_i = 1'b0;
    checks++; if (a_valid_o !== 1'b1 || a_data_o !== 8'h5A) begin failures++; $display("FAIL single_out got=v%0b/%h exp=v1/5a", a_valid_o, a_data_o); end
    checks++; if (b_valid_o !== 1'b0) begin failures++; $display("FAIL single_b got=%0b exp=0", b_valid_o); end
    tick();
    checks++; if (a_valid_o !== 1'b0) begin failures++; $display("FAIL single_pop got=%0b exp=0", a_valid_o); end
  endtask

  task automatic test_fill_b();
    idle_inputs();
    in_valid_i = 1'b1; in_sel_i = 1'b1; in_data_i = 8'hB3; tick();
    in_data_i = 8'hC4; tick();
    checks++; if (b_count_o !== CNT_W'(2)) begin failures++; $display("FAIL fill_b_count got=%0d exp=2", b_count_o); end
    in_data_i = 8'h99;
    #1;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL fill_b_ready got=%0b exp=0", in_ready_o); end
    tick();
    in_sel_i = 1'b0; in_data_i = 8'h11;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL fill_a_ready got=%0b exp=1", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    checks++; if (a_count_o !== CNT_W'(1) || a_data_o !== 8'h11) begin failures++; $display("FAIL fill_a_out got=%0d/%h exp=1/11", a_count_o, a_data_o); end
  endtask

  // Expects B to hold B3,C4 and A to hold 11 from test_fill_b.
  task automatic test_full_pop();
    idle_inputs();
    b_ready_i = 1'b1; in_valid_i = 1'b1; in_sel_i = 1'b1; in_data_i = 8'h77;
    #1;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL fullpop_ready got=%0b exp=0", in_ready_o); end
    checks++; if (b_data_o !== 8'hB3) begin failures++; $display("FAIL fullpop_head got=%h exp=b3", b_data_o); end
    tick();
    checks++; if (last_acc !== 1'b0 || in_ready_o !== 1'b1) begin failures++; $display("FAIL fullpop_next_ready got=%0b exp=1", in_ready_o); end
    checks++; if (b_data_o !== 8'hC4) begin failures++; $display("FAIL fullpop_c4 got=%h exp=c4", b_data_o); end
    tick();
    in_valid_i = 1'b0;
    checks++; if (b_data_o !== 8'h77 || b_count_o !== CNT_W'(1)) begin failures++; $display("FAIL fullpop_77 got=%h/%0d exp=77/1", b_data_o, b_count_o); end
    a_ready_i = 1'b1;
    tick();
    checks++; if (b_valid_o !== 1'b0 || a_valid_o !== 1'b0) begin failures++; $display("FAIL fullpop_drain got=%0b%0b exp=00", a_valid_o, b_valid_o); end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] got_a[$];
    logic [DATA_W-1:0] got_b[$];
    logic [DATA_W-1:0] exp_v;
    int i;
    int cyc;
    idle_inputs();
    i = 0; cyc = 0;
    while (!(i == 10 && exp_a_q.size() == 0 && exp_b_q.size() == 0) && cyc < 200) begin
      a_ready_i = 1'($urandom_range(0, 1));
      b_ready_i = 1'($urandom_range(0, 1));
      in_valid_i = (i < 10);
      in_data_i  = DATA_W'(i);
      in_sel_i   = 1'(i % 2);
      #1;
      checks++; if (a_count_o > CNT_W'(DEPTH) || b_count_o > CNT_W'(DEPTH)) begin failures++; $display("FAIL wrap_count_max got=%0d/%0d exp<=%0d", a_count_o, b_count_o, DEPTH); end
      if (a_valid_o && a_ready_i) got_a.push_back(a_data_o);
      if (b_valid_o && b_ready_i) got_b.push_back(b_data_o);
      tick();
      if (last_acc) i++;
      cyc++;
    end
    in_valid_i = 1'b0;
    checks++; if (cyc >= 200) begin failures++; $display("FAIL wrap_timeout got=%0d cycles exp<200", cyc); end
    checks++; if (got_a.size() != 5 || got_b.size() != 5) begin failures++; $display("FAIL wrap_sizes got=%0d/%0d exp=5/5", got_a.size(), got_b.size()); end
    for (int k = 0; k < 5; k++) begin
      exp_v = DATA_W'(2 * k);
      checks++; if (k >= got_a.size() || got_a[k] !== exp_v) begin failures++; $display("FAIL wrap_a[%0d] exp=%h", k, exp_v); end
      exp_v = DATA_W'(2 * k + 1);
      checks++; if (k >= got_b.size() || got_b[k] !== exp_v) begin failures++; $display("FAIL wrap_b[%0d] exp=%h", k, exp_v); end
    end
  endtask

  task automatic test_random_traffic();
    bit hold;
    idle_inputs();
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        in_valid_i = ($urandom_range(0, 9) < 7);
        in_sel_i   = 1'($urandom_range(0, 1));
        in_data_i  = DATA_W'($urandom);
      end
      a_ready_i = ($urandom_range(0, 3) != 0);
      b_ready_i = ($urandom_range(0, 3) == 0);
      #1;
      checks++; if (in_ready_o !== ((in_sel_i ? exp_b_q.size() : exp_a_q.size()) < DEPTH)) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b", c, in_ready_o); end
      checks++; if (a_valid_o !== (exp_a_q.size() != 0) || a_count_o !== CNT_W'(exp_a_q.size())) begin failures++; $display("FAIL rnd_a_state c=%0d got=v%0b/%0d exp=%0d", c, a_valid_o, a_count_o, exp_a_q.size()); end
      checks++; if (b_valid_o !== (exp_b_q.size() != 0) || b_count_o !== CNT_W'(exp_b_q.size())) begin failures++; $display("FAIL rnd_b_state c=%0d got=v%0b/%0d exp=%0d", c, b_valid_o, b_count_o, exp_b_q.size()); end
      if (exp_a_q.size() != 0) begin
        checks++; if (a_data_o !== exp_a_q[0]) begin failures++; $display("FAIL rnd_a_data c=%0d got=%h exp=%h", c, a_data_o, exp_a_q[0]); end
      end
      if (exp_b_q.size() != 0) begin
        checks++; if (b_data_o !== exp_b_q[0]) begin failures++; $display("FAIL rnd_b_data c=%0d got=%h exp=%h", c, b_data_o, exp_b_q[0]); end
      end
      tick();
      hold = in_valid_i && !last_acc;
    end
    in_valid_i = 1'b0; a_ready_i = 1'b1; b_ready_i = 1'b1;
    repeat (DEPTH + 1) tick();
    checks++; if (a_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%0b%0b exp=00", a_valid_o, b_valid_o); end
  endtask

`ifdef STREAM_DEMUX2_STATS_EN
  task automatic test_stats();
    int cyc;
    logic [15:0] exp_b;
    idle_inputs();
    exp_b = (n_pop_b > 65535) ? 16'hFFFF : 16'(n_pop_b);
    checks++; if (b_xfer_cnt_o !== exp_b) begin failures++; $display("FAIL stats_b got=%h exp=%h", b_xfer_cnt_o, exp_b); end
    in_valid_i = 1'b1; in_sel_i = 1'b0; a_ready_i = 1'b1;
    cyc = 0;
    while (n_pop_a < 70000 && cyc < 70100) begin
      in_data_i = DATA_W'($urandom);
      tick();
      cyc++;
      if (n_pop_a == 1000) begin
        checks++; if (a_xfer_cnt_o !== 16'(n_pop_a)) begin failures++; $display("FAIL stats_a_mid got=%h exp=%h", a_xfer_cnt_o, 16'(n_pop_a)); end
      end
    end
    in_valid_i = 1'b0;
    checks++; if (n_pop_a < 70000) begin failures++; $display("FAIL stats_timeout got=%0d pops exp=70000", n_pop_a); end
    checks++; if (a_xfer_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL stats_a_sat got=%h exp=ffff", a_xfer_cnt_o); end
    exp_b = (n_pop_b > 65535) ? 16'hFFFF : 16'(n_pop_b);
    checks++; if (b_xfer_cnt_o !== exp_b) begin failures++; $display("FAIL stats_b_end got=%h exp=%h", b_xfer_cnt_o, exp_b); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    n_pop_a = 0; n_pop_b = 0; last_acc = 1'b0;
    test_reset();
    test_single_beat();
    test_fill_b();
    test_full_pop();
    test_wrap();
    test_random_traffic();
`ifdef STREAM_DEMUX2_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux2.md
Name: stream_demux2

Overview:
- 1-to-2 stream demultiplexer; the routing counterpart of the 2:1 byte mux.
- Accepts one data stream with a per-beat select and routes each beat to output port A (sel=0) or B (sel=1).
- Each output port has its own small FIFO, so one stalled consumer never corrupts the other port's data.
- Sits between a single producer and two independent valid/ready consumers.

Parameters:
- DATA_W, 8, data width in bits.
- DEPTH, 2, entries per output FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  producer has a beat.
- in_ready_o  output  1  block can accept the beat on in_data_i/in_sel_i.
- in_data_i  input  DATA_W  input beat data.
- in_sel_i  input  1  destination: 0 = A, 1 = B.
- a_valid_o  output  1  port A FIFO non-empty.
- a_ready_i  input  1  port A consumer accepts.
- a_data_o  output  DATA_W  port A head data.
- b_valid_o  output  1  port B FIFO non-empty.
- b_ready_i  input  1  port B consumer accepts.
- b_data_o  output  DATA_W  port B head data.
- a_count_o  output  $clog2(DEPTH+1)  port A occupancy.
- b_count_o  output  $clog2(DEPTH+1)  port B occupancy.

Behaviour:
- Reset (async assert, sync use after release):
  - all FIFO storage, pointers and counts cleared;
  - a_valid_o, b_valid_o = 0; a_data_o, b_data_o = 0; counts = 0;
  - in_ready_o = 0 while reset is high.
- Input handshake:
  - in_ready_o = !reset && !full[in_sel_i] (combinational from in_sel_i and FIFO state).
  - Transfer occurs when in_valid_i && in_ready_o; the beat is written to FIFO[in_sel_i] on that edge.
  - Producer must hold in_data_i and in_sel_i stable while in_valid_i=1 and in_ready_o=0.
- Output handshake, per port X:
  - X_valid_o = count_X != 0; X_data_o = FIFO head (storage read, no extra register).
  - Pop occurs when X_valid_o && X_ready_i; head advances on that edge.
- Latency: beat accepted at edge N is visible on X_valid_o/X_data_o after edge N when FIFO X was empty. One cycle; no combinational in-to-out pass-through.
- Ordering: per-port FIFO order is preserved. No ordering relation between A and B.
- Simultaneous push and pop on the same port:
  - Allowed when the port is not full; count unchanged, pointers both advance.
  - When full, in_ready_o=0 for that sel, even if the consumer pops in the same cycle (no bypass). Space frees on the next cycle.
- Full: count_X == DEPTH. Empty: count_X == 0.
- Pointers: $clog2(DEPTH) bits; wrap from DEPTH-1 to 0.
- A push to A and a pop from B in the same cycle are fully independent.
- Backpressure isolation: a stalled port B only blocks beats with sel=1. Beats with sel=0 still flow, but a blocked sel=1 beat at the head of the input stream stalls the producer (in-order input).
- Reset asserted mid-stream: all contents are discarded immediately (async); outputs return to reset values in the same cycle.
- X_valid_o never drops without a pop. X_data_o is stable while X_valid_o && !X_ready_i.

Optional Feature:
- Macro STREAM_DEMUX2_STATS_EN.
- When defined, adds two output ports, both reset to 0:
  - a_xfer_cnt_o, 16-bit;
  - b_xfer_cnt_o, 16-bit.
- Each counter increments once per completed output pop on its port and saturates at 16'hFFFF; it does not wrap.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset check: assert reset mid-cycle with 2 beats held in A → a_valid_o=0, a_count_o=0, in_ready_o=0 immediately. After release, in_ready_o=1 and a_data_o=00.
- Single beat: data=8'h5A, sel=0 pushed at edge N, a_ready_i=1 → a_valid_o=1 with a_data_o=5A after edge N, popped at edge N+1. b_valid_o stays 0.
- Fill port B: b_ready_i=0, push B3, C4 with sel=1 → b_count_o=2 and in_ready_o=0 for sel=1. A sel=0 beat 11 offered alone is accepted (in_ready_o=1).
- Full with concurrent pop: B full, b_ready_i=1 while offering sel=1 beat 77 → no accept that cycle. Accepted next cycle; B then outputs C4 then 77 in order.
- Wrap-around: 10 beats 00..09 with alternating sel, both readies random 50% → A receives 00,02,04,06,08 and B receives 01,03,05,07,09 in order. No loss or duplication; counts never exceed 2.
- With STREAM_DEMUX2_STATS_EN defined: 70000 pops on A → a_xfer_cnt_o=FFFF (saturated); b_xfer_cnt_o equals the B pop count.
